cpu_host_sequencer: RTL and testbench
=====================================

# cpu_host_sequencer

Sequencer that owns the HPS↔CPU program/data exchange on the FPGA side. It drains instruction words from the HPS-to-FPGA FIFO into instruction memory until a terminator word arrives, then runs the RV64I core (`cpu`) by gating its clock and releasing its reset. When the core signals completion, it halts the core and streams every data-memory entry back through the FPGA-to-HPS FIFO as two 32-bit words, upper half first. It sits between the `hps_fpga` FIFO ports and the `cpu` memory side-ports, and replaces ad-hoc top-level control.

## Interface
Parameters:
- `IMEM_DEPTH`, 1024: instruction-memory words; IMEM address width is $clog2(IMEM_DEPTH).
- `DMEM_DEPTH`, 256: data-memory entries dumped; DMEM address width is $clog2(DMEM_DEPTH).
- `TERM_WORD`, 32'hFFFF_FFFF: terminator word that ends loading; it is never written to IMEM.
- `RUN_TIMEOUT`, 1_000_000: maximum run cycles; used only when `SEQ_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1: single clock (CLOCK_50 domain), used for everything.
- `rst`  in  1: asynchronous, active-high reset.
- `h2f_empty`  in  1: HPS-to-FPGA FIFO empty (csr readdata bit1).
- `h2f_readdata`  in  32: FIFO read data.
- `h2f_read`  out  1: one-cycle FIFO pop.
- `f2h_full`  in  1: FPGA-to-HPS FIFO full (csr readdata bit0).
- `f2h_writedata`  out  32: FIFO write data.
- `f2h_write`  out  1: one-cycle FIFO push.
- `imem_we`  out  1: IMEM write strobe.
- `imem_addr`  out  $clog2(IMEM_DEPTH): IMEM word address.
- `imem_wdata`  out  32: IMEM write data.
- `dmem_addr`  out  $clog2(DMEM_DEPTH): DMEM read address.
- `dmem_rdata`  in  64: DMEM read data; registered, valid 1 cycle after `dmem_addr`.
- `cpu_done`  in  1: core finished (last-PC flag), level.
- `cpu_clk_en`  out  1: core clock gate enable.
- `cpu_rst`  out  1: core reset, active-high.
- `busy`  out  1: high in every state except IDLE.
- `imem_overflow`  out  1: sticky; more than IMEM_DEPTH words were received.
- `timeout`  out  1: sticky; the run was aborted by the watchdog.

## Operation
- State set: IDLE, RD_REQ, RD_GAP, RD_CAP, START, RUN, HALT, DM_ADDR, DM_WAIT, WR_HI, WR_LO, DM_NEXT.
- IDLE: if `!h2f_empty`, go to RD_REQ. Entering RD_REQ from IDLE at the start of a program clears `imem_addr`, `imem_overflow` and `timeout`.
- RD_REQ: `h2f_read`=1. Go to RD_GAP.
- RD_GAP: `h2f_read`=0. Go to RD_CAP.
- RD_CAP, when `h2f_readdata`==TERM_WORD: go to START.
- RD_CAP, otherwise, with `imem_addr` < IMEM_DEPTH: pulse `imem_we` with the data and increment `imem_addr` the following cycle.
- RD_CAP, otherwise, with IMEM full: drop the word and set `imem_overflow`.
- RD_CAP exit for non-terminator words: go to RD_REQ if `!h2f_empty`, else to a load-wait substate of IDLE. Load-wait behaves like IDLE but does not clear the address.
- START: `cpu_rst`=1, `cpu_clk_en`=1 for exactly one cycle, so the core sees one reset edge. Go to RUN.
- RUN: `cpu_rst`=0, `cpu_clk_en`=1. When `cpu_done`=1, go to HALT.
- HALT: `cpu_clk_en`=0. Clear `dmem_addr`. Go to DM_ADDR.
- DM_ADDR: present `dmem_addr`. Go to DM_WAIT.
- DM_WAIT: capture `dmem_rdata` into a 64-bit holding register. Go to WR_HI.
- WR_HI: stall while `f2h_full`. Otherwise push holding[63:32] and go to WR_LO.
- WR_LO: stall while `f2h_full`. Otherwise push holding[31:0] and go to DM_NEXT.
- DM_NEXT: if `dmem_addr`==DMEM_DEPTH-1, go to IDLE. Otherwise increment `dmem_addr` and go to DM_ADDR.
- Exactly 2×DMEM_DEPTH pushes happen per run, in address order 0..DMEM_DEPTH-1.
- `cpu_rst` is 1 in every state except RUN; the core is held in reset while loading and dumping.
- `cpu_clk_en` is 1 only in START and RUN.
- An empty program (terminator as the first word) is legal: the core runs from whatever is already in IMEM.

## Timing
- Reset values:
  - State IDLE.
  - `h2f_read`=0, `f2h_write`=0, `imem_we`=0.
  - `imem_addr`=0, `dmem_addr`=0, `f2h_writedata`=0, `imem_wdata`=0.
  - `cpu_clk_en`=0, `cpu_rst`=1, `busy`=0, `imem_overflow`=0, `timeout`=0.
- All outputs are registered.
- Read latency: `h2f_readdata` is sampled in RD_CAP, 2 cycles after the `h2f_read` pulse.
- Best-case load rate is one word per 3 cycles.
- `imem_we` is a single cycle, coincident with stable `imem_addr`/`imem_wdata`.
- `f2h_write` is a single-cycle pulse, never asserted while `f2h_full` was sampled high the same cycle. Data is stable with the strobe.
- Best-case dump is 5 cycles per entry.
- `cpu_done` is ignored outside RUN. If it is already high at RUN entry, HALT follows the next cycle.
- Reset asserted mid-operation returns to IDLE immediately and drops all strobes in the same cycle. A partial IMEM load is not rolled back.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - A run counter clears in START and increments each RUN cycle.
  - On reaching RUN_TIMEOUT with no `cpu_done`, set `timeout` and go to HALT; the dump proceeds normally.
- `SEQ_TIMEOUT_EN` not defined:
  - No counter is built; RUN waits indefinitely for `cpu_done`.
  - `timeout` is tied to 0.

## Test plan
- Push 3 words (0x00500093, 0x00108113, 0x00000013), then 0xFFFFFFFF → IMEM writes at addresses 0, 1, 2 with those values; `cpu_rst` high for 1 cycle in START, then RUN.
- `cpu_done` raised 20 cycles into RUN, DMEM[0]=0x1122334455667788, DMEM_DEPTH=4 → 8 pushes; the first two are 0x11223344 then 0x55667788; IDLE after the last push.
- Hold `f2h_full`=1 for 10 cycles during WR_LO → no push while full; the word is pushed the cycle after full drops, with no duplicate.
- With IMEM_DEPTH=4, push 6 words plus the terminator → exactly 4 IMEM writes, `imem_overflow`=1, run starts.
- Assert `rst` mid-dump at entry 2 → next cycle: IDLE, `cpu_rst`=1, `f2h_write`=0, `busy`=0.
- `SEQ_TIMEOUT_EN` with RUN_TIMEOUT=100, `cpu_done` held 0 → HALT after 100 RUN cycles, `timeout`=1, full dump of 2×DMEM_DEPTH words.

Source files
------------

// File: rtl/cpu_host_sequencer.sv
// Loads the RV64I core's program from the HPS FIFO, runs the core, then dumps data memory back to the HPS.
// Optional run watchdog is built only when SEQ_TIMEOUT_EN is defined.
module cpu_host_sequencer #(
  parameter int          IMEM_DEPTH  = 1024,
  parameter int          DMEM_DEPTH  = 256,
  parameter logic [31:0] TERM_WORD   = 32'hFFFF_FFFF,
  parameter int          RUN_TIMEOUT = 1_000_000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          h2f_empty,
  input  logic [31:0]                   h2f_readdata,
  output logic                          h2f_read,
  input  logic                          f2h_full,
  output logic [31:0]                   f2h_writedata,
  output logic                          f2h_write,
  output logic                          imem_we,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  output logic [31:0]                   imem_wdata,
  output logic [$clog2(DMEM_DEPTH)-1:0] dmem_addr,
  input  logic [63:0]                   dmem_rdata,
  input  logic                          cpu_done,
  output logic                          cpu_clk_en,
  output logic                          cpu_rst,
  output logic                          busy,
  output logic                          imem_overflow,
  output logic                          timeout
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  typedef enum logic [3:0] {
    IDLE, RD_REQ, RD_GAP, RD_CAP, START, RUN,
    HALT, DM_ADDR, DM_WAIT, WR_HI, WR_LO, DM_NEXT
  } state_t;

  state_t       state;
  logic         load_wait;
  logic [IAW:0] imem_cnt;
  logic [63:0]  holding;

  if (RUN_TIMEOUT < 1) begin : g_bad_timeout
    $error("cpu_host_sequencer: RUN_TIMEOUT must be positive");
  end

  // One extra count bit lets the sequencer tell "IMEM full" apart from address 0.
  assign imem_addr = imem_cnt[IAW-1:0];

`ifdef SEQ_TIMEOUT_EN
  localparam int RCW = $clog2(RUN_TIMEOUT + 1);
  logic [RCW-1:0] run_cnt;
`else
  assign timeout = 1'b0;
`endif

  // Every output is a register, so each transition loads the values the next state needs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      load_wait     <= 1'b0;
      imem_cnt      <= '0;
      holding       <= '0;
      h2f_read      <= 1'b0;
      f2h_write     <= 1'b0;
      f2h_writedata <= '0;
      imem_we       <= 1'b0;
      imem_wdata    <= '0;
      dmem_addr     <= '0;
      cpu_clk_en    <= 1'b0;
      cpu_rst       <= 1'b1;
      busy          <= 1'b0;
      imem_overflow <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      timeout       <= 1'b0;
      run_cnt       <= '0;
`endif
    end else begin
      h2f_read  <= 1'b0;
      imem_we   <= 1'b0;
      f2h_write <= 1'b0;
      if (imem_we) imem_cnt <= imem_cnt + (IAW+1)'(1);

      case (state)
        IDLE: begin
          if (!h2f_empty) begin
            if (!load_wait) begin
              imem_cnt      <= '0;
              imem_overflow <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
              timeout       <= 1'b0;
`endif
            end
            h2f_read <= 1'b1;
            busy     <= 1'b1;
            state    <= RD_REQ;
          end
        end
        RD_REQ: state <= RD_GAP;
        RD_GAP: state <= RD_CAP;
        RD_CAP: begin
          if (h2f_readdata == TERM_WORD) begin
            load_wait  <= 1'b0;
            cpu_clk_en <= 1'b1;
            state      <= START;
          end else begin
            if (imem_cnt < (IAW+1)'(IMEM_DEPTH)) begin
              imem_we    <= 1'b1;
              imem_wdata <= h2f_readdata;
            end else begin
              imem_overflow <= 1'b1;
            end
            if (!h2f_empty) begin
              h2f_read <= 1'b1;
              state    <= RD_REQ;
            end else begin
              load_wait <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        START: begin
          cpu_rst <= 1'b0;
          state   <= RUN;
`ifdef SEQ_TIMEOUT_EN
          run_cnt <= '0;
`endif
        end
        RUN: begin
          if (cpu_done) begin
            cpu_clk_en <= 1'b0;
            cpu_rst    <= 1'b1;
            state      <= HALT;
          end
`ifdef SEQ_TIMEOUT_EN
          else if (run_cnt == RCW'(RUN_TIMEOUT - 1)) begin
            timeout    <= 1'b1;
            cpu_clk_en <= 1'b0;
            cpu_rst    <= 1'b1;
            state      <= HALT;
          end else begin
            run_cnt <= run_cnt + RCW'(1);
          end
`endif
        end
        HALT: begin
          dmem_addr <= '0;
          state     <= DM_ADDR;
        end
        DM_ADDR: state <= DM_WAIT;
        DM_WAIT: begin
          holding <= dmem_rdata;
          state   <= WR_HI;
        end
        WR_HI: begin
          if (!f2h_full) begin
            f2h_write     <= 1'b1;
            f2h_writedata <= holding[63:32];
            state         <= WR_LO;
          end
        end
        WR_LO: begin
          if (!f2h_full) begin
            f2h_write     <= 1'b1;
            f2h_writedata <= holding[31:0];
            state         <= DM_NEXT;
          end
        end
        DM_NEXT: begin
          if (dmem_addr == DAW'(DMEM_DEPTH - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            dmem_addr <= dmem_addr + DAW'(1);
            state     <= DM_ADDR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_host_sequencer.sv
// Self-checking bench for cpu_host_sequencer: table of program runs with random words and DMEM contents
// compared against a queue-based model of load, run and dump; a SEQ_TIMEOUT_EN build adds a watchdog run.
module tb_cpu_host_sequencer;

  localparam int          IMEM_DEPTH  = 4;
  localparam int          DMEM_DEPTH  = 4;
  localparam int          RUN_TIMEOUT = 100;
  localparam logic [31:0] TERM        = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        h2f_empty = 1'b1;
  logic [31:0] h2f_readdata = '0;
  logic        h2f_read;
  logic        f2h_full = 1'b0;
  logic [31:0] f2h_writedata;
  logic        f2h_write;
  logic        imem_we;
  logic [1:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [1:0]  dmem_addr;
  logic [63:0] dmem_rdata = '0;
  logic        cpu_done = 1'b0;
  logic        cpu_clk_en;
  logic        cpu_rst;
  logic        busy;
  logic        imem_overflow;
  logic        timeout;

  always #5 clk = ~clk;

  cpu_host_sequencer #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .DMEM_DEPTH (DMEM_DEPTH),
    .TERM_WORD  (TERM),
    .RUN_TIMEOUT(RUN_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .h2f_empty    (h2f_empty),
    .h2f_readdata (h2f_readdata),
    .h2f_read     (h2f_read),
    .f2h_full     (f2h_full),
    .f2h_writedata(f2h_writedata),
    .f2h_write    (f2h_write),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .dmem_addr    (dmem_addr),
    .dmem_rdata   (dmem_rdata),
    .cpu_done     (cpu_done),
    .cpu_clk_en   (cpu_clk_en),
    .cpu_rst      (cpu_rst),
    .busy         (busy),
    .imem_overflow(imem_overflow),
    .timeout      (timeout)
  );

  // Data memory with one cycle of read latency
  logic [63:0] dmem_model [DMEM_DEPTH];
  always @(posedge clk) dmem_rdata <= dmem_model[dmem_addr];

  typedef struct {
    bit fixed;
    int n_words;
    int done_delay;
    bit stall;
    bit split;
    bit rst_mid;
    int exp_writes;
    bit exp_ovf;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] h2f_q[$];
  logic [31:0] words[$];
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] push_q[$];
  int          push_cyc_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          reads, start_cnt, run_cnt, full_viol;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and record what the DUT did during the cycle that just ended.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (h2f_read) begin
      reads++;
      if (h2f_q.size() > 0) h2f_readdata = h2f_q.pop_front();
    end
    h2f_empty = (h2f_q.size() == 0);
    if (imem_we) begin
      wr_addr_q.push_back(int'(imem_addr));
      wr_data_q.push_back(imem_wdata);
    end
    if (f2h_write) begin
      push_q.push_back(f2h_writedata);
      push_cyc_q.push_back(cyc);
      if (f2h_full) full_viol++;
    end
    if (cpu_clk_en && cpu_rst) start_cnt++;
    if (cpu_clk_en && !cpu_rst) run_cnt++;
  endtask

  task automatic applyStimulus(input vec_t v);
    int n, k, guard, hold, stall_state, drop_cyc, exp_pushes, exp_run;
    logic [31:0] exp_q[$];
    words.delete(); wr_addr_q.delete(); wr_data_q.delete();
    push_q.delete(); push_cyc_q.delete();
    reads = 0; start_cnt = 0; run_cnt = 0; full_viol = 0;
    stall_state = 0; hold = 0; drop_cyc = 0;

    if (v.fixed) words = {32'h00500093, 32'h00108113, 32'h00000013};
    else for (int i = 0; i < v.n_words; i++) words.push_back($urandom & 32'h7FFF_FFFF);
    n = words.size();
    for (int a = 0; a < DMEM_DEPTH; a++) dmem_model[a] = {$urandom, $urandom};
    if (v.fixed) dmem_model[0] = 64'h1122334455667788;
    cpu_done = (v.done_delay == 0);

    k = v.split ? n / 2 : n;
    for (int i = 0; i < k; i++) h2f_q.push_back(words[i]);
    if (!v.split) h2f_q.push_back(TERM);
    h2f_empty = (h2f_q.size() == 0);
    if (v.split) begin
      guard = 0;
      while (!(h2f_empty && !busy) && guard < 100) begin tick(); guard++; end
      repeat (4) tick();
      for (int i = k; i < n; i++) h2f_q.push_back(words[i]);
      h2f_q.push_back(TERM);
      h2f_empty = 1'b0;
    end

    guard = 0;
    while (!cpu_clk_en && guard < 300) begin tick(); guard++; end
    checkOutput("run_started", cpu_clk_en, 1);

    guard = 0;
    while (busy && guard < 3000) begin
      tick();
      guard++;
      if (v.done_delay > 0 && run_cnt == v.done_delay) cpu_done = 1'b1;
      if (v.stall) begin
        if (stall_state == 0 && f2h_write) begin
          f2h_full = 1'b1; hold = 10; stall_state = 1;
        end else if (stall_state == 1) begin
          hold--;
          if (hold == 0) begin f2h_full = 1'b0; drop_cyc = cyc; stall_state = 2; end
        end
      end
      if (v.rst_mid && f2h_write && dmem_addr == 2'd2) begin
        rst = 1'b1;
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_f2h_write", f2h_write, 0);
        checkOutput("rst_cpu_rst", cpu_rst, 1);
        checkOutput("rst_cpu_clk_en", cpu_clk_en, 0);
        tick();
        rst = 1'b0;
      end
    end
    checkOutput("dump_finished", busy, 0);
    cpu_done = 1'b0;
    f2h_full = 1'b0;

    // Reference: the first IMEM_DEPTH words land at consecutive addresses, DMEM comes back hi then lo.
    checkOutput("fifo_pops", reads, n + 1);
    checkOutput("imem_write_count", wr_addr_q.size(), v.exp_writes);
    for (int i = 0; i < v.exp_writes && i < wr_addr_q.size(); i++) begin
      checkOutput($sformatf("imem_addr[%0d]", i), wr_addr_q[i], i);
      checkOutput($sformatf("imem_wdata[%0d]", i), wr_data_q[i], words[i]);
    end
    checkOutput("imem_overflow", imem_overflow, v.exp_ovf);
    checkOutput("start_cycles", start_cnt, 1);
    exp_run = (v.done_delay < 0) ? RUN_TIMEOUT : ((v.done_delay == 0) ? 1 : v.done_delay);
    checkOutput("run_cycles", run_cnt, exp_run);
    checkOutput("timeout_flag", timeout, (v.done_delay < 0));

    for (int a = 0; a < DMEM_DEPTH; a++) begin
      exp_q.push_back(dmem_model[a][63:32]);
      exp_q.push_back(dmem_model[a][31:0]);
    end
    exp_pushes = v.rst_mid ? 5 : 2 * DMEM_DEPTH;
    checkOutput("push_count", push_q.size(), exp_pushes);
    for (int i = 0; i < exp_pushes && i < push_q.size(); i++)
      checkOutput($sformatf("push[%0d]", i), push_q[i], exp_q[i]);
    checkOutput("push_while_full", full_viol, 0);
    if (v.stall && push_cyc_q.size() >= 2)
      checkOutput("stall_release_cycle", push_cyc_q[1], drop_cyc + 1);
    checkOutput("end_cpu_rst", cpu_rst, 1);
    checkOutput("end_cpu_clk_en", cpu_clk_en, 0);
  endtask

  initial begin
    for (int a = 0; a < DMEM_DEPTH; a++) dmem_model[a] = '0;
    repeat (3) tick();
    checkOutput("reset_h2f_read", h2f_read, 0);
    checkOutput("reset_f2h_write", f2h_write, 0);
    checkOutput("reset_imem_we", imem_we, 0);
    checkOutput("reset_imem_addr", imem_addr, 0);
    checkOutput("reset_dmem_addr", dmem_addr, 0);
    checkOutput("reset_f2h_writedata", f2h_writedata, 0);
    checkOutput("reset_imem_wdata", imem_wdata, 0);
    checkOutput("reset_cpu_clk_en", cpu_clk_en, 0);
    checkOutput("reset_cpu_rst", cpu_rst, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_imem_overflow", imem_overflow, 0);
    checkOutput("reset_timeout", timeout, 0);
    rst = 1'b0;
    repeat (2) tick();

    // fixed, n_words, done_delay, stall, split, rst_mid, exp_writes, exp_ovf
    vecs.push_back('{1'b1, 3, 20, 1'b0, 1'b0, 1'b0, 3, 1'b0});
    vecs.push_back('{1'b0, 6, 5,  1'b0, 1'b0, 1'b0, 4, 1'b1});
    vecs.push_back('{1'b0, 0, 3,  1'b0, 1'b0, 1'b0, 0, 1'b0});
    vecs.push_back('{1'b0, 4, 0,  1'b1, 1'b0, 1'b0, 4, 1'b0});
    vecs.push_back('{1'b0, 5, 7,  1'b0, 1'b1, 1'b0, 4, 1'b1});
    vecs.push_back('{1'b0, 2, 4,  1'b0, 1'b0, 1'b1, 2, 1'b0});
    vecs.push_back('{1'b0, 3, 12, 1'b1, 1'b0, 1'b0, 3, 1'b0});
`ifdef SEQ_TIMEOUT_EN
    vecs.push_back('{1'b0, 2, -1, 1'b0, 1'b0, 1'b0, 2, 1'b0});
`endif

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      repeat (3) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
